// File: rtl/mini_risc_pkg.sv
// Shared definitions for the KGP mini-RISC control path: opcodes, FSM states,
// write-port/mux encodings, ALU codes and the packed control-bundle type.
package mini_risc_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned BR_W   = 5;
    localparam int unsigned RW_W   = 2;
    localparam int unsigned WM_W   = 2;
    localparam int unsigned WCNT_W = 3;

    localparam logic [OP_W-1:0] OP_RALU = 6'b000000;
    localparam logic [OP_W-1:0] OP_IALU = 6'b000001;
    localparam logic [OP_W-1:0] OP_LW   = 6'b000010;
    localparam logic [OP_W-1:0] OP_SW   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BR   = 6'b000100;
    localparam logic [OP_W-1:0] OP_CALL = 6'b000101;
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    localparam logic [RW_W-1:0] RW_NONE = 2'b00;
    localparam logic [RW_W-1:0] RW_RS   = 2'b01;
    localparam logic [RW_W-1:0] RW_RT   = 2'b10;
    localparam logic [RW_W-1:0] RW_RA   = 2'b11;

    localparam logic [WM_W-1:0] WM_PC   = 2'b00;
    localparam logic [WM_W-1:0] WM_DMEM = 2'b01;
    localparam logic [WM_W-1:0] WM_ALU  = 2'b10;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'd3;

    // Every data_path control input for one cycle
    typedef struct packed {
        logic             ir_load;
        logic             pc_write;
        logic [RW_W-1:0]  reg_write;
        logic             imm_mux_ctrl;
        logic             alu_mux_ctrl;
        logic [ALU_W-1:0] alu_op;
        logic             dmem_enable;
        logic             dmem_write_enable;
        logic [WM_W-1:0]  reg_write_mux_ctrl;
        logic [BR_W-1:0]  br_op;
        logic             illegal;
    } ctrl_t;

    // True for every opcode the core implements (halt included)
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_RALU, OP_IALU, OP_LW, OP_SW, OP_BR, OP_CALL, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_decode.sv
// Combinational control decode for the multi-cycle sequencer.
// Ports: state (current FSM state), op/fn (opcode/func in effect this cycle),
// last_mem (final MEM wait cycle) -> ctrl (full control bundle).
module mc_ctrl_decode
    import mini_risc_pkg::*;
(
    input  state_e          state,
    input  logic [OP_W-1:0] op,
    input  logic [FN_W-1:0] fn,
    input  logic            last_mem,
    output ctrl_t           ctrl
);

    logic unused_fn5;
    assign unused_fn5 = fn[5];

    // Per-state control map; everything defaults to idle
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: ctrl.ir_load = 1'b1;
            ST_DECODE: begin
                // Unknown opcodes retire immediately as a NOP
                if (!is_legal(op)) begin
                    ctrl.illegal  = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                case (op)
                    OP_RALU: ctrl.alu_op = fn[ALU_W-1:0];
                    OP_IALU: begin
                        ctrl.alu_op       = fn[ALU_W-1:0];
                        ctrl.alu_mux_ctrl = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        ctrl.alu_op       = ALU_ADD;
                        ctrl.imm_mux_ctrl = 1'b1;
                        ctrl.alu_mux_ctrl = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.br_op    = fn[BR_W-1:0];
                        ctrl.pc_write = 1'b1;
                    end
                    OP_CALL: begin
                        ctrl.br_op              = fn[BR_W-1:0];
                        ctrl.reg_write          = RW_RA;
                        ctrl.reg_write_mux_ctrl = WM_PC;
                        ctrl.pc_write           = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                // Address path held from EXEC for the whole access
                ctrl.alu_op       = ALU_ADD;
                ctrl.imm_mux_ctrl = 1'b1;
                ctrl.alu_mux_ctrl = 1'b1;
                ctrl.dmem_enable  = 1'b1;
                if (op == OP_SW) begin
                    ctrl.dmem_write_enable = 1'b1;
                    ctrl.pc_write          = last_mem;
                end
            end
            ST_WB: begin
                ctrl.pc_write = 1'b1;
                if (op == OP_LW) begin
                    ctrl.reg_write          = RW_RT;
                    ctrl.reg_write_mux_ctrl = WM_DMEM;
                    ctrl.dmem_enable        = 1'b1;
                    ctrl.alu_op             = ALU_ADD;
                    ctrl.imm_mux_ctrl       = 1'b1;
                    ctrl.alu_mux_ctrl       = 1'b1;
                end else begin
                    ctrl.reg_write          = RW_RS;
                    ctrl.reg_write_mux_ctrl = WM_ALU;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control sequencer for the KGP mini-RISC core.
// Inputs: clk, rst (sync, active-high), opcode/func from data_path.
// Outputs: all data_path controls (decoded from state + latched op/func),
// sticky halted, one-cycle illegal pulse, retired-instruction counter.
module mc_control_unit
    import mini_risc_pkg::*;
#(
    parameter int unsigned DMEM_LATENCY = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   func,
    output logic              ir_load,
    output logic              pc_write,
    output logic [RW_W-1:0]   reg_write,
    output logic              imm_mux_ctrl,
    output logic              alu_mux_ctrl,
    output logic [ALU_W-1:0]  alu_op,
    output logic              dmem_enable,
    output logic              dmem_write_enable,
    output logic [WM_W-1:0]   reg_write_mux_ctrl,
    output logic [BR_W-1:0]   br_op,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [FN_W-1:0]     fn_q, fn_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic [OP_W-1:0]     op_sel;
    logic [FN_W-1:0]     fn_sel;
    logic                last_mem;
    ctrl_t               ctrl_c;

    // DECODE acts on the live fields; every later state uses the latched copy
    assign op_sel   = (state_q == ST_DECODE) ? opcode : op_q;
    assign fn_sel   = (state_q == ST_DECODE) ? func   : fn_q;
    assign last_mem = (wcnt_q == '0);

    mc_ctrl_decode u_decode (
        .state    (state_q),
        .op       (op_sel),
        .fn       (fn_sel),
        .last_mem (last_mem),
        .ctrl     (ctrl_c)
    );

    // Next-state, latch and counter logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fn_d      = fn_q;
        wcnt_d    = wcnt_q;
        halted_d  = halted_q;
        retired_d = ctrl_c.pc_write ? retired_q + CNT_W'(1) : retired_q;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                op_d = opcode;
                fn_d = func;
                if (opcode == OP_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (!is_legal(opcode)) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = ST_MEM;
                    wcnt_d  = WCNT_W'(DMEM_LATENCY);
                end else if (op_q == OP_RALU || op_q == OP_IALU) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = (op_q == OP_SW) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            wcnt_q    <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            wcnt_q    <= wcnt_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Reset overrides every output while asserted
    assign ir_load            = ctrl_c.ir_load & ~rst;
    assign pc_write           = ctrl_c.pc_write & ~rst;
    assign reg_write          = rst ? '0 : ctrl_c.reg_write;
    assign imm_mux_ctrl       = ctrl_c.imm_mux_ctrl & ~rst;
    assign alu_mux_ctrl       = ctrl_c.alu_mux_ctrl & ~rst;
    assign alu_op             = rst ? '0 : ctrl_c.alu_op;
    assign dmem_enable        = ctrl_c.dmem_enable & ~rst;
    assign dmem_write_enable  = ctrl_c.dmem_write_enable & ~rst;
    assign reg_write_mux_ctrl = rst ? '0 : ctrl_c.reg_write_mux_ctrl;
    assign br_op              = rst ? '0 : ctrl_c.br_op;
    assign illegal            = ctrl_c.illegal & ~rst;
    assign halted             = halted_q & ~rst;
    assign retired            = rst ? '0 : retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: expected per-cycle control vectors are
// queued when an instruction is issued and popped against the DUT each cycle.
module tb_mc_control_unit;

    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic [5:0]    func;
    logic          ir_load, pc_write, imm_mux_ctrl, alu_mux_ctrl;
    logic [1:0]    reg_write, reg_write_mux_ctrl;
    logic [3:0]    alu_op;
    logic          dmem_enable, dmem_write_enable, halted, illegal;
    logic [4:0]    br_op;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    mc_control_unit #(.DMEM_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .func               (func),
        .ir_load            (ir_load),
        .pc_write           (pc_write),
        .reg_write          (reg_write),
        .imm_mux_ctrl       (imm_mux_ctrl),
        .alu_mux_ctrl       (alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (dmem_enable),
        .dmem_write_enable  (dmem_write_enable),
        .reg_write_mux_ctrl (reg_write_mux_ctrl),
        .br_op              (br_op),
        .halted             (halted),
        .illegal            (illegal),
        .retired            (retired)
    );

    typedef logic [20:0] vec_t;
    localparam vec_t ZERO = '0;

    vec_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] ret_model = '0;

    // {ir, pc, rw, imm, am, aop, de, dwe, wm, br, halted, illegal}
    function automatic vec_t mk(input logic ir, input logic pc, input logic [1:0] rw,
                                input logic imm, input logic am, input logic [3:0] aop,
                                input logic de, input logic dwe, input logic [1:0] wm,
                                input logic [4:0] br, input logic h, input logic il);
        return {ir, pc, rw, imm, am, aop, de, dwe, wm, br, h, il};
    endfunction

    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
        exp_q.push_back(mk(1, 0, 2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'd0, 0, 0));
        case (op)
            6'b000000, 6'b000001: begin
                exp_q.push_back(ZERO);
                exp_q.push_back(mk(0, 0, 2'b00, 0, op[0], fn[3:0], 0, 0, 2'b00, 5'd0, 0, 0));
                exp_q.push_back(mk(0, 1, 2'b01, 0, 0, 4'd0, 0, 0, 2'b10, 5'd0, 0, 0));
            end
            6'b000011: begin
                exp_q.push_back(ZERO);
                exp_q.push_back(mk(0, 0, 2'b00, 1, 1, 4'd0, 0, 0, 2'b00, 5'd0, 0, 0));
                for (int i = 0; i <= int'(LAT); i++)
                    exp_q.push_back(mk(0, (i == int'(LAT)), 2'b00, 1, 1, 4'd0, 1, 1, 2'b00, 5'd0, 0, 0));
            end
            6'b000010: begin
                exp_q.push_back(ZERO);
                exp_q.push_back(mk(0, 0, 2'b00, 1, 1, 4'd0, 0, 0, 2'b00, 5'd0, 0, 0));
                for (int i = 0; i <= int'(LAT); i++)
                    exp_q.push_back(mk(0, 0, 2'b00, 1, 1, 4'd0, 1, 0, 2'b00, 5'd0, 0, 0));
                exp_q.push_back(mk(0, 1, 2'b10, 1, 1, 4'd0, 1, 0, 2'b01, 5'd0, 0, 0));
            end
            6'b000100: begin
                exp_q.push_back(ZERO);
                exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 4'd0, 0, 0, 2'b00, fn[4:0], 0, 0));
            end
            6'b000101: begin
                exp_q.push_back(ZERO);
                exp_q.push_back(mk(0, 1, 2'b11, 0, 0, 4'd0, 0, 0, 2'b00, fn[4:0], 0, 0));
            end
            6'b111111: begin
                exp_q.push_back(ZERO);
                for (int i = 0; i < 20; i++)
                    exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'd0, 1, 0));
            end
            default: exp_q.push_back(mk(0, 1, 2'b00, 0, 0, 4'd0, 0, 0, 2'b00, 5'd0, 0, 1));
        endcase
    endtask

    // One clock: drive fields (real only in DECODE), compare at negedge, advance
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic real_fields);
        vec_t obs, expv;
        opcode = real_fields ? op : 6'($urandom);
        func   = real_fields ? fn : 6'($urandom);
        @(negedge clk);
        obs  = {ir_load, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
                dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, halted, illegal};
        expv = exp_q.pop_front();
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, expv);
        end
        n_cmp++;
        assert (retired === ret_model) else begin
            n_bad++;
            $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, ret_model);
        end
        n_cmp++;
        assert (!(reg_write != 2'b00 && dmem_write_enable)) else begin
            n_bad++;
            $error("FAIL %s rw_vs_dwe observed rw=%b dwe=%b expected not both", tag,
                   reg_write, dmem_write_enable);
        end
        if (expv[19] && !rst) ret_model = ret_model + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn);
        int idx;
        push_instr(op, fn);
        idx = 0;
        while (exp_q.size() != 0) begin
            step(tag, op, fn, idx == 1);
            idx++;
        end
    endtask

    task automatic do_reset(input string tag, input int cycles);
        rst       = 1'b1;
        ret_model = '0;
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back(ZERO);
            step(tag, 6'd0, 6'd0, 1'b0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        opcode = '0;
        func   = '0;
        do_reset("reset", 2);

        run_instr("xor",  6'b000000, 6'b000011);
        run_instr("addi", 6'b000001, 6'b000000);
        n_cmp++;
        assert (retired === 4'd2) else begin
            n_bad++;
            $error("FAIL retired_after_alu observed=%0d expected=2", retired);
        end

        run_instr("sw",     6'b000011, 6'b101010);
        run_instr("lw",     6'b000010, 6'b110111);
        run_instr("branch", 6'b000100, 6'b000101);
        run_instr("call",   6'b000101, 6'b010011);
        run_instr("illegal", 6'b010101, 6'b000000);

        // Abort an lw in flight: FETCH, DECODE, EXEC then reset
        push_instr(6'b000010, 6'b000000);
        for (int i = 0; i < 3; i++) step("lw_abort", 6'b000010, 6'b000000, i == 1);
        exp_q.delete();
        do_reset("mid_reset", 2);
        run_instr("post_reset_xor", 6'b000000, 6'b000011);

        // Counter wrap: one ALU above plus 15 NOPs lands back on zero
        for (int i = 0; i < 15; i++) run_instr("nop_wrap", 6'b010101, 6'(i));
        n_cmp++;
        assert (retired === 4'd0) else begin
            n_bad++;
            $error("FAIL wrap observed=%0d expected=0", retired);
        end

        run_instr("halt", 6'b111111, 6'b000000);
        do_reset("halt_reset", 1);
        run_instr("after_halt_addi", 6'b000001, 6'b000111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control sequencer for the KGP mini-RISC core. It sits directly upstream of data_path.
- Consumes data_path's opcode_out/func_out and drives every data_path control input, one instruction at a time.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB with a configurable data-memory wait, and provides halt detection and retired-instruction counting.

Parameters:
DMEM_LATENCY, 1, extra wait cycles in MEM before dmem data/write is complete (0..7)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  instruction opcode from data_path opcode_out
func  in  6  function field from data_path func_out
ir_load  out  1  load instruction register from imem
pc_write  out  1  advance/update PC (one pulse per retired instruction)
reg_write  out  2  00 none, 01 write rs (ALU), 10 write rt (load), 11 write $ra (link)
imm_mux_ctrl  out  1  0 = imm field, 1 = offset field
alu_mux_ctrl  out  1  0 = register operand, 1 = immediate operand
alu_op  out  4  ALU operation (0 add, 3 xor, others per func)
dmem_enable  out  1  data memory enable
dmem_write_enable  out  1  data memory write strobe
reg_write_mux_ctrl  out  2  10 ALU result, 01 dmem data, 00 PC+1
br_op  out  5  branch condition code; 0 = no branch
halted  out  1  sticky: halt opcode executed
illegal  out  1  one-cycle pulse in DECODE on unknown opcode
retired  out  CNT_W  count of completed instructions, wraps at 2^CNT_W

Behaviour:
Opcode map:
- 000000 R-ALU: alu_op = func[3:0].
- 000001 I-ALU: alu_op = func[3:0], alu_mux_ctrl = 1.
- 000010 lw.
- 000011 sw.
- 000100 branch: br_op = func[4:0].
- 000101 call.
- 111111 halt.
- Anything else is illegal and treated as a NOP.

States: FETCH, DECODE, EXEC, MEM, WB, HALT. State is a registered FSM. Outputs are decoded combinationally from state plus opcode/func latched in DECODE (op_q, fn_q).

Reset:
- While rst = 1 every output is forced to 0.
- On the next edge: state = FETCH, op_q = fn_q = 0, wait counter = 0, halted = 0, retired = 0.
- Reset mid-instruction aborts it: no pc_write or reg_write is issued.

Per-state outputs (any output not listed is 0):
- FETCH: ir_load = 1. Next state DECODE.
- DECODE: latch opcode/func.
  - Halt goes to HALT.
  - Illegal pulses illegal, then goes to FETCH with pc_write = 1 (retired counts it).
  - All others go to EXEC.
- EXEC:
  - ALU classes: alu_op and alu_mux_ctrl driven; next WB.
  - lw/sw: alu_op = 0, imm_mux_ctrl = 1, alu_mux_ctrl = 1; next MEM.
  - Branch: br_op = fn_q[4:0], pc_write = 1; next FETCH.
  - Call: br_op = fn_q[4:0], reg_write = 11, reg_write_mux_ctrl = 00, pc_write = 1; next FETCH.
- MEM:
  - Held for 1 + DMEM_LATENCY cycles using a 3-bit down-counter loaded on entry.
  - Address controls stay as in EXEC; dmem_enable = 1 throughout.
  - sw: dmem_write_enable = 1 for all MEM cycles. On the last MEM cycle pc_write = 1, then FETCH.
  - lw: dmem_write_enable = 0, then WB.
- WB:
  - ALU classes: reg_write = 01, reg_write_mux_ctrl = 10.
  - lw: reg_write = 10, reg_write_mux_ctrl = 01, with dmem_enable and the lw address controls held.
  - pc_write = 1; next FETCH.
- HALT: all control outputs 0; halted = 1; remains in HALT until rst.

Counting and latency:
- retired increments on every cycle where pc_write = 1.
- Cycle counts per instruction:
  - ALU: 4.
  - Branch/call: 3.
  - sw: 4 + DMEM_LATENCY.
  - lw: 5 + DMEM_LATENCY.
  - Illegal: 2.

Invariants (assert in bench):
- reg_write and dmem_write_enable never both nonzero in the same cycle.
- At most one pc_write per instruction.
- opcode/func changes outside DECODE have no effect.

Decomposition:
- Shared package mini_risc_pkg:
  - Opcode constants OP_RALU, OP_IALU, OP_LW, OP_SW, OP_BR, OP_CALL, OP_HALT.
  - State enum.
  - reg_write encodings RW_NONE, RW_RS, RW_RT, RW_RA.
  - Write-mux encodings WM_PC, WM_DMEM, WM_ALU.
  - ALU codes ALU_ADD = 0, ALU_XOR = 3.
- One natural sub-module: mc_ctrl_decode, a combinational map from (state, op_q, fn_q, last_mem_cycle) to control outputs. The FSM, wait counter and retired counter stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles mid-EXEC of an lw -> all outputs 0 during rst; FETCH with ir_load = 1 on the first cycle after release; retired = 0.
- xor $0,$0 (000000/000011), then addi $0,121 (000001/000000) -> EXEC alu_op = 3, alu_mux_ctrl = 0; WB reg_write = 01, reg_write_mux_ctrl = 10; second instruction has alu_mux_ctrl = 1; retired = 2 after 8 cycles.
- sw with DMEM_LATENCY = 2 -> dmem_enable = dmem_write_enable = 1 for exactly 3 cycles; imm_mux_ctrl = alu_mux_ctrl = 1; reg_write = 0 throughout; pc_write on the 3rd MEM cycle; 6 cycles total.
- lw with DMEM_LATENCY = 1 -> 2 MEM cycles with dmem_write_enable = 0; WB reg_write = 10, reg_write_mux_ctrl = 01; 6 cycles total.
- Branch func = 5'b00101 -> EXEC br_op = 5 and pc_write = 1; no reg_write; back to FETCH after 3 cycles. Call -> reg_write = 11, reg_write_mux_ctrl = 00.
- Opcode 010101 -> illegal pulses 1 cycle, pc_write = 1, retired +1. Then opcode 111111 -> halted = 1 and outputs stay 0 for 20 cycles until rst. Counter wrap with CNT_W = 4: 16 NOPs -> retired returns to 0.
